// File: rtl/g_cbud4le_pkg.sv
// rtl/g_cbud4le_pkg.sv - shared constants and parameter checks for the counter macros
package g_cbud4le_pkg;

  // Count direction encoding on the UP input
  localparam logic G_DIR_UP = 1'b1;
  localparam logic G_DIR_DN = 1'b0;

  // Legal WIDTH is 2..16, legal MODULUS is 2..2**WIDTH
  function automatic bit params_ok(input int width, input int modulus);
    return (width >= 2) && (width <= 16) &&
           (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/g_cnt_tcdec.sv
// rtl/g_cnt_tcdec.sv - terminal-count decode for a modulus-N up/down counter
module g_cnt_tcdec
  import g_cbud4le_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             up_i,
  output logic             term_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  // Up: at or above the top count (covers out-of-range loads); down: at zero
  always_comb begin
    term_o = 1'b0;
    if (up_i == G_DIR_DN) term_o = (value_i == '0);
    else                  term_o = (value_i >= MAX_V);
  end

endmodule

// File: rtl/g_cbud4le.sv
// rtl/g_cbud4le.sv - loadable up/down modulus counter with TCN and cascade CO (option G_CBUD4LE_TCREG_EN)
module g_cbud4le
  import g_cbud4le_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             CE,
  input  logic             CI,
  input  logic             LD,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TCN,
  output logic             CO
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  if (!params_ok(WIDTH, MODULUS)) begin : g_bad_params
    $error("g_cbud4le: WIDTH or MODULUS out of range");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             term_cur;

  // Next count value ignoring reset: load beats count, count needs CE and CI
  always_comb begin
    q_d = q_q;
    if (LD) begin
      q_d = D;
    end else if (CE && CI) begin
      if (UP == G_DIR_UP) q_d = (q_q >= MAX_Q) ? '0 : q_q + 1'b1;
      else                q_d = (q_q == '0) ? MAX_Q : q_q - 1'b1;
    end
  end

  // Count register with synchronous reset overriding load and count
  always_ff @(posedge CK) begin
    if (CD) q_q <= '0;
    else    q_q <= q_d;
  end

  g_cnt_tcdec #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_tcdec_cur (
    .value_i (q_q),
    .up_i    (UP),
    .term_o  (term_cur)
  );

  // Carry-out is zero-latency so a chain of stages ripples in one cycle
  assign CO = term_cur & CE & CI & ~LD & ~CD;
  assign Q  = q_q;

`ifdef G_CBUD4LE_TCREG_EN
  logic term_nxt;
  logic tcn_q;

  g_cnt_tcdec #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_tcdec_nxt (
    .value_i (q_d),
    .up_i    (UP),
    .term_o  (term_nxt)
  );

  // Registered decode of the value Q is about to take, so it stays aligned with Q
  always_ff @(posedge CK) begin
    if (CD) tcn_q <= 1'b1;
    else    tcn_q <= ~term_nxt;
  end

  assign TCN = tcn_q;
`else
  assign TCN = ~term_cur;
`endif

endmodule

// File: tb/tb_g_cbud4le.sv
// tb/tb_g_cbud4le.sv - directed self-checking bench for g_cbud4le
module tb_g_cbud4le;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Instance A: WIDTH=4, MODULUS=16
  logic       a_cd, a_ce, a_ci, a_ld, a_up;
  logic [3:0] a_d, a_q;
  logic       a_tcn, a_co;

  // Instance B: WIDTH=4, MODULUS=10
  logic       b_cd, b_ce, b_ci, b_ld, b_up;
  logic [3:0] b_d, b_q;
  logic       b_tcn, b_co;

  // Cascade pair forming an 8-bit up counter
  logic       c_cd, c_ce, c_ld, c_up;
  logic [7:0] c_d;
  logic [3:0] lo_q, hi_q;
  logic       lo_tcn, hi_tcn, lo_co, hi_co;

  g_cbud4le #(.WIDTH(4), .MODULUS(16)) u_a (
    .CK(clk), .CD(a_cd), .CE(a_ce), .CI(a_ci), .LD(a_ld), .UP(a_up),
    .D(a_d), .Q(a_q), .TCN(a_tcn), .CO(a_co)
  );

  g_cbud4le #(.WIDTH(4), .MODULUS(10)) u_b (
    .CK(clk), .CD(b_cd), .CE(b_ce), .CI(b_ci), .LD(b_ld), .UP(b_up),
    .D(b_d), .Q(b_q), .TCN(b_tcn), .CO(b_co)
  );

  g_cbud4le #(.WIDTH(4), .MODULUS(16)) u_lo (
    .CK(clk), .CD(c_cd), .CE(c_ce), .CI(1'b1), .LD(c_ld), .UP(c_up),
    .D(c_d[3:0]), .Q(lo_q), .TCN(lo_tcn), .CO(lo_co)
  );

  g_cbud4le #(.WIDTH(4), .MODULUS(16)) u_hi (
    .CK(clk), .CD(c_cd), .CE(c_ce), .CI(lo_co), .LD(c_ld), .UP(c_up),
    .D(c_d[7:4]), .Q(hi_q), .TCN(hi_tcn), .CO(hi_co)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_q;
  int exp_tcn;

  initial begin
    a_cd = 1'b1; a_ce = 1'b1; a_ci = 1'b1; a_ld = 1'b0; a_up = 1'b1; a_d = 4'h0;
    b_cd = 1'b1; b_ce = 1'b1; b_ci = 1'b1; b_ld = 1'b0; b_up = 1'b0; b_d = 4'h0;
    c_cd = 1'b1; c_ce = 1'b1; c_ld = 1'b0; c_up = 1'b1; c_d = 8'h00;

    // Reset held for two cycles
    tick();
    tick();
    check("rst_q",   a_q,   0);
    check("rst_tcn", a_tcn, 1);
    check("rst_co",  a_co,  0);

    // Up count 0..15, 0 with TCN/CO active only at 15
    a_cd = 1'b0;
    #1;
    for (int i = 0; i <= 16; i++) begin
      exp_q = i % 16;
      check("up_q",   a_q,   exp_q);
      check("up_tcn", a_tcn, (exp_q == 15) ? 0 : 1);
      check("up_co",  a_co,  (exp_q == 15) ? 1 : 0);
      tick();
    end
    check("up_after_wrap", a_q, 1);

    // Hold with CE=0
    a_ce = 1'b0;
    tick(); tick(); tick();
    check("hold_q",  a_q,  1);
    check("hold_co", a_co, 0);

    // Bring Q to 0 then toggle direction with no count
    a_ld = 1'b1; a_d = 4'h0;
    tick();
    a_ld = 1'b0;
    #1;
    check("dir_q0",      a_q,   0);
    check("dir_tcn_up",  a_tcn, 1);
    a_up = 1'b0;
    #1;
`ifdef G_CBUD4LE_TCREG_EN
    check("dir_tcn_same", a_tcn, 1);
`else
    check("dir_tcn_same", a_tcn, 0);
`endif
    check("dir_co_ce0", a_co, 0);
    tick();
    check("dir_tcn_next", a_tcn, 0);
    check("dir_q_hold",   a_q,   0);

    // Priority: reset beats load and count
    a_up = 1'b1; a_ld = 1'b1; a_d = 4'h5;
    tick();
    check("pri_load5", a_q, 5);
    a_cd = 1'b1; a_ld = 1'b1; a_d = 4'h3; a_ce = 1'b1; a_ci = 1'b1;
    #1;
    check("pri_co_cd", a_co, 0);
    tick();
    check("pri_rst_q", a_q, 0);
    a_cd = 1'b0; a_ld = 1'b0; a_up = 1'b0;
    #1;
    check("pri_co_term", a_co, 1);
    a_ld = 1'b1;
    #1;
    check("pri_co_ld", a_co, 0);
    tick();
    check("pri_ld_q", a_q, 3);
    a_ld = 1'b0; a_ce = 1'b0;

    // Modulus 10 down count from 0: 0,9,8,...,1,0,9
    b_cd = 1'b0;
    #1;
    for (int k = 0; k <= 11; k++) begin
      exp_q = (10 - (k % 10)) % 10;
`ifdef G_CBUD4LE_TCREG_EN
      exp_tcn = (k == 0) ? 1 : ((exp_q == 0) ? 0 : 1);
`else
      exp_tcn = (exp_q == 0) ? 0 : 1;
`endif
      check("m10_q",   b_q,   exp_q);
      check("m10_tcn", b_tcn, exp_tcn);
      check("m10_co",  b_co,  (exp_q == 0) ? 1 : 0);
      tick();
    end
    check("m10_end", b_q, 8);

    // Out-of-range load of 12 counts up and wraps to 0
    b_ld = 1'b1; b_d = 4'hC; b_up = 1'b1;
    tick();
    b_ld = 1'b0;
    #1;
    check("m10_ld12_q",   b_q,   12);
    check("m10_ld12_tcn", b_tcn, 0);
    check("m10_ld12_co",  b_co,  1);
    tick();
    check("m10_wrap_q",   b_q,   0);
    check("m10_wrap_tcn", b_tcn, 1);

    // Cascade from 0x0E
    c_cd = 1'b0; c_ld = 1'b1; c_d = 8'h0E;
    tick();
    c_ld = 1'b0;
    #1;
    check("cas_0e",    {hi_q, lo_q}, 8'h0E);
    check("cas_co_0e", lo_co, 0);
    tick();
    check("cas_0f",    {hi_q, lo_q}, 8'h0F);
    check("cas_co_0f", lo_co, 1);
    tick();
    check("cas_10",    {hi_q, lo_q}, 8'h10);
    check("cas_co_10", lo_co, 0);
    tick();
    check("cas_11",    {hi_q, lo_q}, 8'h11);
    check("cas_hi_co", hi_co, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
